// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-master single-port RAM arbiter with M1 starvation guard
//
// Ports:
//   clk, rst          clock and synchronous active-low reset
//   m0_*              read/write master: req/we/addr/sel/wdata in, ack/rdata out
//   m1_*              read-only master: req/addr in, ack/rdata out
//   ram_*             RAM command out (ce/we/addr/sel/wdata), ram_rdata in
module ram_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_W-1:0]     m0_addr,
  input  logic [DATA_W/8-1:0]   m0_sel,
  input  logic [DATA_W-1:0]     m0_wdata,
  output logic                  m0_ack,
  output logic [DATA_W-1:0]     m0_rdata,
  input  logic                  m1_req,
  input  logic [ADDR_W-1:0]     m1_addr,
  output logic                  m1_ack,
  output logic [DATA_W-1:0]     m1_rdata,
  output logic                  ram_ce,
  output logic                  ram_we,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [DATA_W/8-1:0]   ram_sel,
  output logic [DATA_W-1:0]     ram_wdata,
  input  logic [DATA_W-1:0]     ram_rdata
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1} state_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_e              state_q, state_d;
  logic [3:0]          starve_cnt_q, starve_cnt_d;
  logic                m0_ack_q, m1_ack_q;
  logic [DATA_W-1:0]   m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0]   m1_rdata_q, m1_rdata_d;
  logic                elig0, elig1;

  // A master whose access is ending this cycle still holds req for that
  // same transaction, so it cannot be re-granted at this edge.
  always_comb begin
    elig0 = m0_req && (state_q != ACC0);
    elig1 = m1_req && (state_q != ACC1);

    state_d = IDLE;
    if (elig0 && elig1) begin
      state_d = (starve_cnt_q == LIMIT) ? ACC1 : ACC0;
    end else if (elig0) begin
      state_d = ACC0;
    end else if (elig1) begin
      state_d = ACC1;
    end

    starve_cnt_d = starve_cnt_q;
    if (!m1_req || (state_d == ACC1)) begin
      starve_cnt_d = 4'd0;
    end else if ((state_d == ACC0) && (starve_cnt_q != LIMIT)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end

    // Writes leave m0_rdata untouched.
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    if ((state_q == ACC0) && !m0_we) m0_rdata_d = ram_rdata;
    if (state_q == ACC1)             m1_rdata_d = ram_rdata;
  end

  // RAM command follows the registered grant; forced quiet during reset so
  // an access interrupted by reset can never commit a write.
  always_comb begin
    ram_ce    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_sel   = '0;
    ram_wdata = '0;
    if (rst) begin
      case (state_q)
        ACC0: begin
          ram_ce    = 1'b1;
          ram_we    = m0_we;
          ram_addr  = m0_addr;
          ram_sel   = m0_sel;
          ram_wdata = m0_wdata;
        end
        ACC1: begin
          ram_ce    = 1'b1;
          ram_addr  = m1_addr;
          ram_sel   = '1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      starve_cnt_q <= 4'd0;
      m0_ack_q     <= 1'b0;
      m1_ack_q     <= 1'b0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      m0_ack_q     <= (state_q == ACC0);
      m1_ack_q     <= (state_q == ACC1);
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
    end
  end

  assign m0_ack   = m0_ack_q;
  assign m1_ack   = m1_ack_q;
  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter: ADDR_W, 32, address width of both masters and the RAM port.
REQ-002 Parameter: DATA_W, 32, data width; byte lanes = DATA_W/8 = 4.
REQ-003 Parameter: STARVE_LIMIT, 4, max consecutive M0 grants while M1 waits; legal range 1..15.
REQ-004 Port: clk  in  1  single clock; all state on the rising edge.
REQ-005 Port: rst  in  1  reset, synchronous, active-low.
REQ-006 Port: m0_req  in  1  data-side (MEM stage) request; held with its payload until m0_ack.
REQ-007 Port: m0_we  in  1  1 = write, 0 = read.
REQ-008 Port: m0_addr  in  ADDR_W  M0 byte address.
REQ-009 Port: m0_sel  in  4  M0 byte-lane enables; bit3 = data[31:24].
REQ-010 Port: m0_wdata  in  DATA_W  M0 write data.
REQ-011 Port: m0_ack  out  1  one-cycle completion pulse.
REQ-012 Port: m0_rdata  out  DATA_W  registered read data; valid when m0_ack=1 after a read.
REQ-013 Port: m1_req  in  1  second (read-only) master request; held until m1_ack.
REQ-014 Port: m1_addr  in  ADDR_W  M1 byte address.
REQ-015 Port: m1_ack  out  1  one-cycle completion pulse.
REQ-016 Port: m1_rdata  out  DATA_W  registered read data; valid when m1_ack=1.
REQ-017 Port: ram_ce, ram_we  out  1 each  RAM chip enable and write enable (1 = active).
REQ-018 Port: ram_addr  out  ADDR_W; ram_sel  out  4; ram_wdata  out  DATA_W  RAM command.
REQ-019 Port: ram_rdata  in  DATA_W  RAM read data, combinational from ram_addr.

Function
REQ-020 FSM states: IDLE, ACC0, ACC1; the state is the registered grant.
REQ-021 In ACCx, the RAM command SHALL be driven combinationally from master x: ram_ce=1, ram_addr=mx_addr, ram_we=m0_we (M0) or 0 (M1), ram_sel=m0_sel (M0) or 4'b1111 (M1), ram_wdata=m0_wdata (M0) or 0 (M1).
REQ-022 In IDLE, and whenever rst=0, ram_ce, ram_we, ram_addr, ram_sel and ram_wdata SHALL all be 0.
REQ-023 At the end of ACCx, mx_ack SHALL be set to 1 for exactly the next cycle; for a read, mx_rdata SHALL capture ram_rdata at that same edge.
REQ-024 An M0 write SHALL leave m0_rdata unchanged; a write with m0_sel=0 is still issued and acked.
REQ-025 Access latency: request sampled at edge E, ACCx during cycle E..E+1, ack in cycle E+1..E+2; ack-to-req turnaround is 0 cycles.
REQ-026 Eligibility: master x SHALL be ineligible at the edge that ends ACCx, because its held req belongs to the completing transaction; req seen during its ack cycle is a new request.
REQ-027 Next state SHALL be chosen at every edge from the eligible requesters; with no eligible requester the next state is IDLE.
REQ-028 Priority: M0 SHALL win over M1 unless starve_cnt == STARVE_LIMIT, in which case M1 SHALL win.
REQ-029 starve_cnt (4 bits) SHALL increment on each M0 grant while m1_req=1, saturating at STARVE_LIMIT.
REQ-030 starve_cnt SHALL clear on any M1 grant, and on any edge where m1_req=0.
REQ-031 Both masters requesting continuously SHALL alternate ACC0/ACC1, giving 100% RAM utilisation.
REQ-032 A request dropped before its ack is a protocol violation; behaviour is undefined and is not checked.

Reset
REQ-033 With rst=0 at an edge: state=IDLE, m0_ack=m1_ack=0, m0_rdata=m1_rdata=0, starve_cnt=0.
REQ-034 Reset during ACCx SHALL abandon the access: no ack, and no RAM write commits because of REQ-022.
REQ-035 The first grant SHALL occur at the first edge with rst=1 and an eligible request.

Verification
REQ-036 M1 read only: m1_addr=0x10, RAM[4]=0xDEADBEEF -> ACC1 for 1 cycle, m1_ack pulses next cycle, m1_rdata=0xDEADBEEF.
REQ-037 M0 write m0_sel=4'b0011, m0_wdata=0xAABBCCDD to 0x20, then M0 read of 0x20 -> ram_we=1 only during the write access; the read returns 0xxxxxCCDD (upper two bytes unchanged from preload); m0_rdata unchanged after the write ack.
REQ-038 Same-edge requests from M0 and M1 held continuously -> grant order ACC0, ACC1, ACC0, ACC1, ...; every ack is exactly one cycle; RAM is never idle.
REQ-039 Starvation: M0 issues back-to-back requests with M1 blocked; STARVE_LIMIT=2 (override) -> M1 is granted after at most 2 M0 grants; starve_cnt reads 0 after the M1 grant.
REQ-040 Reset mid-write: rst=0 during ACC0 with m0_we=1 -> RAM word unchanged, no m0_ack, all outputs 0 on the next cycle.
